sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving data bits per frame; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-005 SHALL have port si  input  1  serial data, one bit per clk while shifting.
REQ-006 SHALL have port frame_data  output  WIDTH  last completed frame (holding register).
REQ-007 SHALL have port frame_valid  output  1  frame_data is valid and unconsumed.
REQ-008 SHALL have port frame_ready  input  1  consumer accepts frame_data when high with frame_valid.
REQ-009 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-010 SHALL have port overrun  output  1  sticky flag: a completed frame was dropped.
REQ-011 SHALL have port clr_ovr  input  1  synchronous clear of overrun.

Function
REQ-012 SHALL implement the states IDLE and SHIFT, plus PARITY when the parity feature is compiled in.
REQ-013 IDLE with start=1 SHALL move to SHIFT and clear the bit counter; start=0 SHALL keep the block in IDLE.
REQ-014 SHIFT SHALL sample si each cycle into an internal shift register as {si, sr[WIDTH-1:1]}, so the first bit lands in frame_data[0].
REQ-015 SHALL sample WIDTH bits on cycles 1..WIDTH after the start cycle; after the last bit the block SHALL go to IDLE, or to PARITY when that feature is compiled in.
REQ-016 start asserted outside IDLE SHALL be ignored with no effect on the counter or data.
REQ-017 On frame completion, frame_data SHALL load the shift register and frame_valid SHALL assert in the next cycle; latency from the start cycle is WIDTH+1 cycles.
REQ-018 frame_valid SHALL stay high and frame_data stable until a cycle with frame_valid&&frame_ready, after which frame_valid SHALL clear.
REQ-019 A completion in the same cycle as frame_valid&&frame_ready SHALL load the new frame, keep frame_valid high and leave overrun unchanged.
REQ-020 A completion while frame_valid=1 and frame_ready=0 SHALL drop the new frame, keep the old frame_data and set overrun.
REQ-021 The block SHALL accept a new start in the IDLE cycle right after completion, so back-to-back frames are supported.
REQ-022 overrun SHALL clear only on clr_ovr=1; a set and a clear in the same cycle SHALL leave overrun set.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within a frame.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE and clear the counter, shift register, frame_data (all zeros), frame_valid, overrun and parity_err.
REQ-025 Reset mid-frame SHALL discard the partial frame with no output; the first start after rst_n rises SHALL begin a clean frame.

Configuration
REQ-026 When macro SIPO_FRAME_PARITY_EN is defined:
- the PARITY state SHALL sample one even-parity bit on si after the data bits;
- output parity_err (1 bit) SHALL load with frame_data and be high when the XOR of the data and parity bits is 1;
- latency SHALL be WIDTH+2 cycles.
REQ-027 When the macro is undefined, the PARITY state and the parity_err port SHALL be absent and latency SHALL be WIDTH+1 cycles.

Verification (WIDTH=8)
REQ-028 start, si=1,0,1,1,0,0,1,0, frame_ready=0 -> frame_valid=1 at cycle 9 after start, frame_data=8'h4D, busy low from cycle 9.
REQ-029 With 8'h4D held unaccepted, send frame 8'hFF -> overrun=1, frame_data stays 8'h4D; clr_ovr pulse -> overrun=0.
REQ-030 rst_n low after 3 bits of a frame -> busy=0, frame_valid=0, frame_data=0; next frame 8'hA5 -> frame_data=8'hA5, no overrun.
REQ-031 start re-asserted on cycles 2..5 of a frame -> ignored; frame_data equals the bits sent, valid at cycle 9.
REQ-032 frame_ready=1 throughout, two back-to-back frames 8'h3C then 8'hC3 -> each valid exactly 1 cycle, no overrun.
REQ-033 (SIPO_FRAME_PARITY_EN) 8'h4D with parity bit 0 -> parity_err=0 at cycle 10; parity bit 1 -> parity_err=1 with frame_data=8'h4D.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame capture with a one-deep holding register and sticky overrun flag.
// Optional even-parity bit per frame when SIPO_FRAME_PARITY_EN is defined.
module sipo_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             si,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
`ifdef SIPO_FRAME_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_FRAME_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] frame_new;
  logic             complete;
  logic             load;
  logic             drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    complete   = 1'b0;
    frame_new  = {si, sr[WIDTH-1:1]};
    case (state)
      IDLE: begin
        if (start) next_state = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) begin
`ifdef SIPO_FRAME_PARITY_EN
          next_state = PARITY;
`else
          next_state = IDLE;
          complete   = 1'b1;
`endif
        end
      end
`ifdef SIPO_FRAME_PARITY_EN
      PARITY: begin
        // Data bits are already complete in sr; si carries the parity bit.
        next_state = IDLE;
        complete   = 1'b1;
        frame_new  = sr;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign load = complete && (!frame_valid || frame_ready);
  assign drop = complete && frame_valid && !frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (state == IDLE) begin
      if (start) cnt <= '0;
    end else if (state == SHIFT) begin
      sr  <= {si, sr[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else if (load) begin
      frame_data  <= frame_new;
      frame_valid <= 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
      parity_err  <= (^sr) ^ si;
`endif
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as clr_ovr must win so no loss goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl at WIDTH=8; covers the parity build when SIPO_FRAME_PARITY_EN is defined.
module tb_sipo_frame_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         si = 1'b0;
  logic [W-1:0] frame_data;
  logic         frame_valid;
  logic         frame_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         clr_ovr = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
  logic         parity_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .si(si),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
`ifdef SIPO_FRAME_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start cycle, then W data bits (plus parity); returns in the cycle the frame should be valid.
  task automatic send(input logic [W-1:0] d, input logic par, input logic rdy_final,
                      output logic vld_before);
    logic r;
    r = frame_ready;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      si = d[i];
`ifndef SIPO_FRAME_PARITY_EN
      if (i == W - 1) begin
        vld_before  = frame_valid;
        frame_ready = rdy_final;
      end
`endif
      tick();
    end
`ifdef SIPO_FRAME_PARITY_EN
    si = par;
    vld_before  = frame_valid;
    frame_ready = rdy_final;
    tick();
`else
    if (par === 1'bx) vld_before = 1'bx;
`endif
    frame_ready = r;
    si = 1'b0;
  endtask

  task automatic check_out(input string name);
    int n;
    logic [W-1:0] e;
    n = 0;
    while (!frame_valid && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!frame_valid) begin
      fails++;
      $display("FAIL %s: timeout waiting for frame_valid", name);
    end else if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: output 0x%02h with empty scoreboard", name, frame_data);
    end else begin
      e = exp_q.pop_front();
      if (frame_data !== e) begin
        fails++;
        $display("FAIL %s: frame_data=0x%02h expected 0x%02h", name, frame_data, e);
      end
    end
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({busy, frame_valid, overrun, frame_data} !== {3'b000, {W{1'b0}}}) begin
      fails++;
      $display("FAIL reset: busy=%b valid=%b ovr=%b data=0x%02h expected all zero",
               busy, frame_valid, overrun, frame_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic vb;
    exp_q.push_back(8'h4D);
    send(8'h4D, 1'b0, 1'b0, vb);
    tests++;
    if (vb !== 1'b0) begin
      fails++; $display("FAIL basic_early: valid before latency=%b expected 0", vb);
    end
    tests++;
    if (frame_valid !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_latency: valid=%b busy=%b expected 1/0", frame_valid, busy);
    end
    check_out("basic_4D");
    repeat (3) tick();
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== 8'h4D) begin
      fails++; $display("FAIL basic_hold: valid=%b data=0x%02h expected 1/0x4D", frame_valid, frame_data);
    end
  endtask

  task automatic test_overrun();
    logic vb;
    send(8'hFF, 1'b0, 1'b0, vb);
    tests++;
    if (overrun !== 1'b1 || frame_data !== 8'h4D || frame_valid !== 1'b1) begin
      fails++; $display("FAIL overrun_set: ovr=%b data=0x%02h valid=%b expected 1/0x4D/1",
                        overrun, frame_data, frame_valid);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL overrun_clr: ovr=%b expected 0", overrun);
    end
    clr_ovr = 1'b1;
    send(8'h5A, 1'b0, 1'b0, vb);
    clr_ovr = 1'b0;
    tests++;
    if (overrun !== 1'b1 || frame_data !== 8'h4D) begin
      fails++; $display("FAIL overrun_set_vs_clr: ovr=%b data=0x%02h expected 1/0x4D", overrun, frame_data);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    accept();
    tests++;
    if (frame_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++; $display("FAIL overrun_accept: valid=%b ovr=%b expected 0/0", frame_valid, overrun);
    end
  endtask

  task automatic test_collision();
    logic vb;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b0, 1'b0, vb);
    check_out("collision_first");
    exp_q.push_back(8'h22);
    send(8'h22, 1'b0, 1'b1, vb);
    check_out("collision_second");
    tick();
    tests++;
    if (frame_valid !== 1'b1 || overrun !== 1'b0 || frame_data !== 8'h22) begin
      fails++; $display("FAIL collision_state: valid=%b ovr=%b data=0x%02h expected 1/0/0x22",
                        frame_valid, overrun, frame_data);
    end
    accept();
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] d;
    d = 8'h96;
    exp_q.push_back(d);
    start = 1'b1;
    tick();
    for (int i = 0; i < W; i++) begin
      si = d[i];
      start = (i >= 1 && i <= 4);
      tick();
    end
    start = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
    si = ^d;
    tick();
`endif
    si = 1'b0;
    tests++;
    if (frame_valid !== 1'b1) begin
      fails++; $display("FAIL start_ignored_latency: valid=%b expected 1", frame_valid);
    end
    check_out("start_ignored_data");
  endtask

  task automatic test_reset_midframe();
    logic vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      si = i[0];
      tick();
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if (busy !== 1'b0 || frame_valid !== 1'b0 || frame_data !== 8'h00) begin
      fails++; $display("FAIL reset_midframe: busy=%b valid=%b data=0x%02h expected 0/0/0x00",
                        busy, frame_valid, frame_data);
    end
    tick();
    rst_n = 1'b1;
    si = 1'b0;
    tick();
    exp_q.push_back(8'hA5);
    send(8'hA5, ^8'hA5, 1'b0, vb);
    check_out("reset_next_frame");
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL reset_next_ovr: ovr=%b expected 0", overrun);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic vb;
    frame_ready = 1'b1;
    exp_q.push_back(8'h3C);
    send(8'h3C, ^8'h3C, 1'b1, vb);
    check_out("b2b_first");
    exp_q.push_back(8'hC3);
    send(8'hC3, ^8'hC3, 1'b1, vb);
    tests++;
    if (vb !== 1'b0) begin
      fails++; $display("FAIL b2b_first_width: valid before second=%b expected 0", vb);
    end
    check_out("b2b_second");
    tick();
    tests++;
    if (frame_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++; $display("FAIL b2b_end: valid=%b ovr=%b expected 0/0", frame_valid, overrun);
    end
    frame_ready = 1'b0;
  endtask

`ifdef SIPO_FRAME_PARITY_EN
  task automatic test_parity();
    logic vb;
    exp_q.push_back(8'h4D);
    send(8'h4D, 1'b0, 1'b0, vb);
    tests++;
    if (vb !== 1'b0 || frame_valid !== 1'b1 || parity_err !== 1'b0) begin
      fails++; $display("FAIL parity_good: vb=%b valid=%b perr=%b expected 0/1/0", vb, frame_valid, parity_err);
    end
    check_out("parity_good_data");
    accept();
    exp_q.push_back(8'h4D);
    send(8'h4D, 1'b1, 1'b0, vb);
    tests++;
    if (parity_err !== 1'b1) begin
      fails++; $display("FAIL parity_bad: perr=%b expected 1", parity_err);
    end
    check_out("parity_bad_data");
    accept();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_collision();
    test_start_ignored();
    test_reset_midframe();
    test_back_to_back();
`ifdef SIPO_FRAME_PARITY_EN
    test_parity();
`endif
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
